updown_count_sequencer: RTL

//  Control/scheduling front-end for the 8-bit up/down LED counter: issues the count tick at the
//  SW-selected speed and drives the UD (direction) and En (enable) inputs of the counter.

---
 rtl/updown_count_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/updown_count_sequencer.sv
// Tick scheduler and direction/enable driver for the 8-bit up/down LED counter.
// Optional build macro SINGLE_STEP_EN enables single-step counting while paused.
module updown_count_sequencer #(
  parameter int          DIV0     = 50_000_000,
  parameter int          DIV1     = 25_000_000,
  parameter int          DIV2     = 12_500_000,
  parameter int          DIV3     = 6_250_000,
  parameter int          PW       = 26,
  parameter logic [7:0]  LIMIT_HI = 8'hFF,
  parameter logic [7:0]  LIMIT_LO = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] SW,
  input  logic       ud_in,
  input  logic       mode,
  input  logic       start,
  input  logic       pause_btn,
  input  logic       step,
  input  logic [7:0] cnt,
  output logic       tick,
  output logic       UD,
  output logic       En,
  output logic       rev,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN_UP   = 2'b01,
    RUN_DOWN = 2'b10,
    PAUSED   = 2'b11
  } state_t;

  state_t          state_q, state_n;
  logic            ud_q, ud_n;
  logic            en_q, en_n;
  logic            tick_q, tick_n;
  logic            rev_q, rev_n;
  logic [PW-1:0]   presc_q, presc_n;
  logic [PW-1:0]   div_last;
  logic [1:0]      sw_q;
  logic            saved_q, saved_n;
  logic            pause_q;
  logic            pause_edge;
  logic            sw_chg;
  logic            step_edge;
  logic            cur_up;
  logic            next_up;
  logic            at_limit;
  logic            step_blocked;

  assign pause_edge = pause_btn & ~pause_q;
  assign sw_chg     = (SW != sw_q);

`ifdef SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign step_edge = step & ~step_q;
`else
  logic unused_step;

  assign unused_step = step;
  assign step_edge   = 1'b0;
`endif

  // Last prescaler value of the selected period; the tick fires when it is reached.
  always_comb begin
    div_last = PW'(DIV0 - 1);
    case (SW)
      2'b00:   div_last = PW'(DIV0 - 1);
      2'b01:   div_last = PW'(DIV1 - 1);
      2'b10:   div_last = PW'(DIV2 - 1);
      default: div_last = PW'(DIV3 - 1);
    endcase
  end

  always_comb begin
    state_n      = state_q;
    ud_n         = ud_q;
    en_n         = 1'b0;
    tick_n       = 1'b0;
    rev_n        = 1'b0;
    presc_n      = presc_q;
    saved_n      = saved_q;
    cur_up       = (state_q == RUN_UP);
    next_up      = cur_up;
    at_limit     = 1'b0;
    step_blocked = mode & (saved_q ? (cnt >= LIMIT_HI) : (cnt <= LIMIT_LO));

    case (state_q)
      IDLE: begin
        presc_n = '0;
        if (start) begin
          next_up = mode | ud_in;
          state_n = next_up ? RUN_UP : RUN_DOWN;
          ud_n    = next_up;
          en_n    = 1'b1;
        end
      end

      RUN_UP, RUN_DOWN: begin
        if (mode) begin
          at_limit = cur_up ? (cnt >= LIMIT_HI) : (cnt <= LIMIT_LO);
          next_up  = at_limit ? ~cur_up : cur_up;
        end else begin
          next_up  = ud_in;
        end

        // Parking the prescaler at its last value makes the first tick in the
        // new direction land one cycle after the reversal.
        if (at_limit) begin
          rev_n   = 1'b1;
          presc_n = div_last;
        end else if (sw_chg) begin
          presc_n = '0;
        end else if (presc_q >= div_last) begin
          presc_n = '0;
          tick_n  = 1'b1;
        end else begin
          presc_n = presc_q + PW'(1);
        end

        if (pause_edge) begin
          saved_n = next_up;
          state_n = PAUSED;
          tick_n  = 1'b0;
          if (!at_limit) presc_n = sw_chg ? '0 : presc_q;
        end else begin
          state_n = next_up ? RUN_UP : RUN_DOWN;
          ud_n    = next_up;
          en_n    = 1'b1;
        end
      end

      PAUSED: begin
        if (sw_chg) presc_n = '0;
        if (pause_edge) begin
          state_n = saved_q ? RUN_UP : RUN_DOWN;
          ud_n    = saved_q;
          en_n    = 1'b1;
        end else if (step_edge && !step_blocked) begin
          en_n   = 1'b1;
          tick_n = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ud_q    <= 1'b1;
      en_q    <= 1'b0;
      tick_q  <= 1'b0;
      rev_q   <= 1'b0;
      presc_q <= '0;
      saved_q <= 1'b1;
      pause_q <= 1'b0;
      sw_q    <= SW;
    end else begin
      state_q <= state_n;
      ud_q    <= ud_n;
      en_q    <= en_n;
      tick_q  <= tick_n;
      rev_q   <= rev_n;
      presc_q <= presc_n;
      saved_q <= saved_n;
      pause_q <= pause_btn;
      sw_q    <= SW;
    end
  end

  assign state = state_q;
  assign UD    = ud_q;
  assign En    = en_q;
  assign tick  = tick_q;
  assign rev   = rev_q;

endmodule
